// File: rtl/rvfi_trace_check.sv
// Compares each checked RVFI retirement against a spec model's decoded result over a window
// of DEPTH retirements. It also checks the PC chain between consecutive checked retirements.
module rvfi_trace_check #(
   parameter int NRET         = 1,
   parameter int XLEN         = 32,
   parameter int DEPTH        = 8,
   parameter int STRICT_ORDER = 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          check,
   input  logic [NRET-1:0]               rvfi_valid,
   input  logic [NRET-1:0]               rvfi_trap,
   input  logic [5*NRET-1:0]             rvfi_rd_addr,
   input  logic [XLEN*NRET-1:0]          rvfi_rd_wdata,
   input  logic [XLEN*NRET-1:0]          rvfi_pc_rdata,
   input  logic [XLEN*NRET-1:0]          rvfi_pc_wdata,
   input  logic [NRET-1:0]               spec_valid,
   input  logic [NRET-1:0]               spec_trap,
   input  logic [5*NRET-1:0]             spec_rd_addr,
   input  logic [XLEN*NRET-1:0]          spec_rd_wdata,
   input  logic [XLEN*NRET-1:0]          spec_pc_wdata,
   output logic                          busy,
   output logic                          done,
   output logic                          fail,
   output logic [$clog2(NRET)+1-1:0]     fail_chan,
   output logic [2:0]                    fail_code,
   output logic [$clog2(DEPTH+1)-1:0]    ret_cnt
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int FW = $clog2(NRET)+1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_DONE   = 2'd2,
      S_FAIL   = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [XLEN-1:0] r_ref_pc;
   logic [XLEN-1:0] w_ref_pc_nxt;
   logic            r_ref_valid;
   logic            w_ref_valid_nxt;
   logic [CW-1:0]   r_ret_cnt;
   logic [CW-1:0]   w_ret_cnt_nxt;
   logic [FW-1:0]   r_fail_chan;
   logic [FW-1:0]   w_fail_chan_nxt;
   logic [2:0]      r_fail_code;
   logic [2:0]      w_fail_code_nxt;
   logic            r_busy;
   logic            r_done;
   logic            r_fail;

   logic            w_hit;
   logic [FW-1:0]   w_hit_chan;
   logic [2:0]      w_hit_code;
   logic [CW-1:0]   w_checked;
   logic [XLEN-1:0] w_chain_pc;
   logic            w_chain_valid;

   // Walk valid channels in ascending order; the chain PC advances through each clean retirement
   always_comb begin
      logic [CW-1:0] v_room;
      logic          v_gap;
      logic [2:0]    v_code;
      w_hit         = 1'b0;
      w_hit_chan    = {FW{1'b0}};
      w_hit_code    = 3'd0;
      w_checked     = {CW{1'b0}};
      w_chain_pc    = r_ref_pc;
      w_chain_valid = r_ref_valid;
      v_room        = CW'(DEPTH) - r_ret_cnt;
      v_gap         = 1'b0;
      v_code        = 3'd0;
      for (int c = 0; c < NRET; c++) begin
         if (rvfi_valid[c] && !w_hit && (w_checked < v_room)) begin
            if (!spec_valid[c]) begin
               v_code = 3'd1;
            end else if (spec_trap[c] != rvfi_trap[c]) begin
               v_code = 3'd2;
            end else if (!spec_trap[c] &&
                         ((spec_rd_addr[c*5 +: 5] != rvfi_rd_addr[c*5 +: 5]) ||
                          (spec_rd_wdata[c*XLEN +: XLEN] != rvfi_rd_wdata[c*XLEN +: XLEN]))) begin
               v_code = 3'd3;
            end else if (!spec_trap[c] &&
                         (spec_pc_wdata[c*XLEN +: XLEN] != rvfi_pc_wdata[c*XLEN +: XLEN])) begin
               v_code = 3'd4;
            end else if (w_chain_valid && (rvfi_pc_rdata[c*XLEN +: XLEN] != w_chain_pc)) begin
               v_code = 3'd5;
            end else if ((STRICT_ORDER != 0) && v_gap) begin
               v_code = 3'd6;
            end else begin
               v_code = 3'd0;
            end
            if (v_code != 3'd0) begin
               w_hit      = 1'b1;
               w_hit_chan = FW'(c);
               w_hit_code = v_code;
            end else begin
               w_checked     = w_checked + CW'(1);
               w_chain_pc    = rvfi_pc_wdata[c*XLEN +: XLEN];
               w_chain_valid = 1'b1;
            end
         end else begin
            v_code = 3'd0;
         end
         if (!rvfi_valid[c]) begin
            v_gap = 1'b1;
         end else begin
            v_gap = v_gap;
         end
      end
   end

   // Next-state and next-value logic for the window FSM
   always_comb begin
      w_state_nxt     = r_state;
      w_ret_cnt_nxt   = r_ret_cnt;
      w_fail_chan_nxt = r_fail_chan;
      w_fail_code_nxt = r_fail_code;
      w_ref_pc_nxt    = r_ref_pc;
      w_ref_valid_nxt = r_ref_valid;
      case (r_state)
         S_ACTIVE: begin
            w_ret_cnt_nxt   = r_ret_cnt + w_checked;
            w_ref_pc_nxt    = w_chain_pc;
            w_ref_valid_nxt = w_chain_valid;
            if (w_hit) begin
               w_state_nxt     = S_FAIL;
               w_fail_chan_nxt = w_hit_chan;
               w_fail_code_nxt = w_hit_code;
            end else if ((r_ret_cnt + w_checked) == CW'(DEPTH)) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_ACTIVE;
            end
         end
         S_IDLE, S_DONE, S_FAIL: begin
            if (check) begin
               w_state_nxt     = S_ACTIVE;
               w_ret_cnt_nxt   = {CW{1'b0}};
               w_fail_chan_nxt = {FW{1'b0}};
               w_fail_code_nxt = 3'd0;
               w_ref_valid_nxt = 1'b0;
            end else begin
               w_state_nxt = r_state;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, window bookkeeping and registered status outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_ret_cnt   <= {CW{1'b0}};
         r_fail_chan <= {FW{1'b0}};
         r_fail_code <= 3'd0;
         r_ref_pc    <= {XLEN{1'b0}};
         r_ref_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_fail      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_ret_cnt   <= w_ret_cnt_nxt;
         r_fail_chan <= w_fail_chan_nxt;
         r_fail_code <= w_fail_code_nxt;
         r_ref_pc    <= w_ref_pc_nxt;
         r_ref_valid <= w_ref_valid_nxt;
         r_busy      <= (w_state_nxt == S_ACTIVE);
         r_done      <= (w_state_nxt == S_DONE);
         r_fail      <= (w_state_nxt == S_FAIL);
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign fail      = r_fail;
   assign fail_chan = r_fail_chan;
   assign fail_code = r_fail_code;
   assign ret_cnt   = r_ret_cnt;

endmodule

// File: tb/tb_rvfi_trace_check.sv
// Two checkers (NRET=1/DEPTH=4 and NRET=2/DEPTH=3) share one retirement stream; each is
// compared every cycle against a window model built from the retirement rules.
module tb_rvfi_trace_check;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  chk;
   logic [1:0]  vld, trp, svld, strp;
   logic [9:0]  rda, srda;
   logic [63:0] rdw, srdw, pcr, pcw, spcw;

   logic       a_busy, a_done, a_fail;
   logic [0:0] a_chan;
   logic [2:0] a_code;
   logic [2:0] a_cnt;
   logic       b_busy, b_done, b_fail;
   logic [1:0] b_chan;
   logic [2:0] b_code;
   logic [1:0] b_cnt;

   int errors = 0;
   int checks = 0;

   // model: mode 0 idle, 1 active, 2 done, 3 fail
   int          m_st[2], m_cnt[2], m_chan[2], m_code[2];
   bit          m_refv[2];
   logic [31:0] m_ref[2];
   logic [31:0] tb_pc;

   always #5 clk = ~clk;

   rvfi_trace_check #(.NRET(1), .XLEN(32), .DEPTH(4), .STRICT_ORDER(1)) u_a (
      .clock(clk), .reset(rst), .check(chk[0]),
      .rvfi_valid(vld[0:0]), .rvfi_trap(trp[0:0]), .rvfi_rd_addr(rda[4:0]),
      .rvfi_rd_wdata(rdw[31:0]), .rvfi_pc_rdata(pcr[31:0]), .rvfi_pc_wdata(pcw[31:0]),
      .spec_valid(svld[0:0]), .spec_trap(strp[0:0]), .spec_rd_addr(srda[4:0]),
      .spec_rd_wdata(srdw[31:0]), .spec_pc_wdata(spcw[31:0]),
      .busy(a_busy), .done(a_done), .fail(a_fail), .fail_chan(a_chan),
      .fail_code(a_code), .ret_cnt(a_cnt));

   rvfi_trace_check #(.NRET(2), .XLEN(32), .DEPTH(3), .STRICT_ORDER(1)) u_b (
      .clock(clk), .reset(rst), .check(chk[1]),
      .rvfi_valid(vld), .rvfi_trap(trp), .rvfi_rd_addr(rda),
      .rvfi_rd_wdata(rdw), .rvfi_pc_rdata(pcr), .rvfi_pc_wdata(pcw),
      .spec_valid(svld), .spec_trap(strp), .spec_rd_addr(srda),
      .spec_rd_wdata(srdw), .spec_pc_wdata(spcw),
      .busy(b_busy), .done(b_done), .fail(b_fail), .fail_chan(b_chan),
      .fail_code(b_code), .ret_cnt(b_cnt));

   function automatic int chan_code(input int c, input bit gap, input bit refv,
                                    input logic [31:0] refpc);
      if (!svld[c]) return 1;
      if (strp[c] != trp[c]) return 2;
      if (!strp[c] && ((srda[c*5 +: 5] != rda[c*5 +: 5]) ||
                       (srdw[c*32 +: 32] != rdw[c*32 +: 32]))) return 3;
      if (!strp[c] && (spcw[c*32 +: 32] != pcw[c*32 +: 32])) return 4;
      if (refv && (pcr[c*32 +: 32] != refpc)) return 5;
      if (gap) return 6;
      return 0;
   endfunction

   task automatic model_step(input int d);
      int nret, depth, used, code;
      bit gap, stop;
      nret  = (d == 0) ? 1 : 2;
      depth = (d == 0) ? 4 : 3;
      if (rst) begin
         m_st[d] = 0; m_cnt[d] = 0; m_chan[d] = 0; m_code[d] = 0; m_refv[d] = 1'b0;
      end else if (m_st[d] == 1) begin
         used = 0; gap = 1'b0; stop = 1'b0;
         for (int c = 0; c < nret; c++) begin
            if (!stop) begin
               if (!vld[c]) gap = 1'b1;
               else if (m_cnt[d] + used >= depth) stop = 1'b1;
               else begin
                  code = chan_code(c, gap, m_refv[d], m_ref[d]);
                  if (code != 0) begin
                     m_st[d] = 3; m_chan[d] = c; m_code[d] = code; stop = 1'b1;
                  end else begin
                     used++; m_refv[d] = 1'b1; m_ref[d] = pcw[c*32 +: 32];
                  end
               end
            end
         end
         m_cnt[d] += used;
         if (m_st[d] == 1 && m_cnt[d] == depth) m_st[d] = 2;
      end else if (chk[d]) begin
         m_st[d] = 1; m_cnt[d] = 0; m_chan[d] = 0; m_code[d] = 0; m_refv[d] = 1'b0;
      end
   endtask

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      cmp("a_busy", 32'(a_busy), 32'(m_st[0] == 1));
      cmp("a_done", 32'(a_done), 32'(m_st[0] == 2));
      cmp("a_fail", 32'(a_fail), 32'(m_st[0] == 3));
      cmp("a_ret_cnt", 32'(a_cnt), m_cnt[0]);
      cmp("a_fail_chan", 32'(a_chan), m_chan[0]);
      cmp("a_fail_code", 32'(a_code), m_code[0]);
      cmp("b_busy", 32'(b_busy), 32'(m_st[1] == 1));
      cmp("b_done", 32'(b_done), 32'(m_st[1] == 2));
      cmp("b_fail", 32'(b_fail), 32'(m_st[1] == 3));
      cmp("b_ret_cnt", 32'(b_cnt), m_cnt[1]);
      cmp("b_fail_chan", 32'(b_chan), m_chan[1]);
      cmp("b_fail_code", 32'(b_code), m_code[1]);
   endtask

   task automatic step();
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic clear_in();
      rst = 1'b0; chk = 2'b00; vld = 2'b00; trp = 2'b00; svld = 2'b00; strp = 2'b00;
      rda = 10'd0; srda = 10'd0; rdw = 64'd0; srdw = 64'd0;
      pcr = 64'd0; pcw = 64'd0; spcw = 64'd0;
   endtask

   task automatic set_match(input int c, input logic [31:0] pc, input logic [31:0] npc);
      logic [4:0]  a;
      logic [31:0] w;
      a = 5'($urandom_range(31));
      w = $urandom();
      vld[c] = 1'b1; svld[c] = 1'b1; trp[c] = 1'b0; strp[c] = 1'b0;
      rda[c*5 +: 5] = a; srda[c*5 +: 5] = a;
      rdw[c*32 +: 32] = w; srdw[c*32 +: 32] = w;
      pcr[c*32 +: 32] = pc; pcw[c*32 +: 32] = npc; spcw[c*32 +: 32] = npc;
   endtask

   task automatic corrupt(input int c);
      case ($urandom_range(7))
         0: svld[c] = 1'b0;
         1: trp[c] = 1'b1;
         2: srdw[c*32 +: 32] = srdw[c*32 +: 32] ^ 32'h1;
         3: srda[c*5 +: 5] = srda[c*5 +: 5] ^ 5'h1;
         4: spcw[c*32 +: 32] = spcw[c*32 +: 32] ^ 32'h4;
         5: pcr[c*32 +: 32] = pcr[c*32 +: 32] ^ 32'h8;
         6: begin
            trp[c] = 1'b1; strp[c] = 1'b1;
            srdw[c*32 +: 32] = srdw[c*32 +: 32] ^ 32'h3;
            spcw[c*32 +: 32] = spcw[c*32 +: 32] ^ 32'h10;
         end
         default: begin end
      endcase
   endtask

   task automatic gen_random();
      logic [31:0] nxt;
      clear_in();
      rst    = ($urandom_range(63) == 0);
      chk[0] = ($urandom_range(7) == 0);
      chk[1] = ($urandom_range(7) == 0);
      for (int c = 0; c < 2; c++) begin
         if ($urandom_range((c == 0) ? 1 : 3) == 0) begin
            nxt = ($urandom_range(3) == 0) ? ($urandom() & 32'hFFFF_FFFC) : tb_pc + 32'd4;
            set_match(c, tb_pc, nxt);
            tb_pc = nxt;
            if ($urandom_range(5) == 0) corrupt(c);
         end
      end
   endtask

   initial begin
      tb_pc = 32'd0;
      clear_in();
      rst = 1'b1;
      step();
      step();
      cmp("reset_a_busy", 32'(a_busy), 32'd0);
      cmp("reset_b_cnt", 32'(b_cnt), 32'd0);

      // four clean retirements fill the NRET=1 window
      clear_in(); chk[0] = 1'b1; step();
      clear_in(); set_match(0, 32'h0, 32'h4); step();
      clear_in(); set_match(0, 32'h4, 32'h8); step();
      clear_in(); set_match(0, 32'h8, 32'hC); step();
      clear_in(); set_match(0, 32'hC, 32'h10); step();
      cmp("r17_done", 32'(a_done), 32'd1);
      cmp("r17_cnt", 32'(a_cnt), 32'd4);
      cmp("r17_fail", 32'(a_fail), 32'd0);

      // rd data mismatch on the second retirement
      clear_in(); chk[0] = 1'b1; step();
      clear_in(); set_match(0, 32'h0, 32'h4); step();
      clear_in(); set_match(0, 32'h4, 32'h8);
      srdw[31:0] = 32'h5; rdw[31:0] = 32'h6; step();
      cmp("r18_fail", 32'(a_fail), 32'd1);
      cmp("r18_code", 32'(a_code), 32'd3);
      cmp("r18_cnt", 32'(a_cnt), 32'd1);

      // broken PC chain, then a new window ignores the stale chain
      clear_in(); chk[0] = 1'b1; step();
      clear_in(); set_match(0, 32'h0, 32'h10); step();
      clear_in(); set_match(0, 32'h14, 32'h18); step();
      cmp("r21_code", 32'(a_code), 32'd5);
      clear_in(); chk[0] = 1'b1; step();
      cmp("r21_rearm_fail", 32'(a_fail), 32'd0);
      clear_in(); set_match(0, 32'h200, 32'h204); step();
      cmp("r21_first_ok", 32'(a_busy), 32'd1);

      // channel 1 valid without channel 0
      clear_in(); chk[1] = 1'b1; step();
      clear_in(); set_match(1, 32'h0, 32'h4); step();
      cmp("r19_code", 32'(b_code), 32'd6);
      cmp("r19_chan", 32'(b_chan), 32'd1);

      // window fills mid-cycle; the fourth retirement is ignored
      clear_in(); chk[1] = 1'b1; step();
      clear_in(); set_match(0, 32'h0, 32'h4); set_match(1, 32'h4, 32'h8); step();
      clear_in(); set_match(0, 32'h8, 32'hC); set_match(1, 32'hC, 32'h10);
      svld[1] = 1'b0; step();
      cmp("r20_done", 32'(b_done), 32'd1);
      cmp("r20_cnt", 32'(b_cnt), 32'd3);

      // check while active is ignored, then reset mid-window
      clear_in(); chk = 2'b11; step();
      clear_in(); set_match(0, 32'h0, 32'h4); chk = 2'b11; step();
      clear_in(); set_match(0, 32'h4, 32'h8); step();
      cmp("r22_pre_cnt", 32'(a_cnt), 32'd2);
      clear_in(); rst = 1'b1; chk = 2'b11; set_match(0, 32'h8, 32'hC); step();
      cmp("r22_busy", 32'(a_busy), 32'd0);
      cmp("r22_cnt", 32'(a_cnt), 32'd0);

      for (int i = 0; i < 800; i++) begin
         gen_random();
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
